// File: rtl/mmu_table_init_if.sv
// MMU map RAM control bundle: address, read/write strobes, data drive value and its output enable.
interface mmu_table_init_if;
    logic [7:0] addr;
    logic       nRD;
    logic       nWR;
    logic [7:0] dout;
    logic       doe;

    modport master (output addr, nRD, nWR, dout, doe);
    modport slave  (input  addr, nRD, nWR, dout, doe);
endinterface

// File: rtl/mmu_table_init.sv
// Fills every MMU map entry with {CS_FIELD, idx[5:0]} while stalling the CPU through mrdy;
// passes the CPU-side MMU RAM controls straight through when idle.
//
//   state | meaning
//   IDLE  | passthrough, waiting for start or the post-reset auto fill
//   SETUP | address/data/doe driven, nWR high
//   WRITE | nWR low for WR_CYCLES cycles
//   HOLD  | nWR high, address/data held for hold time
//   DONE  | doe released, done set, bus handed back next cycle
module mmu_table_init #(
    parameter int unsigned ENTRIES   = 256,
    parameter int unsigned WR_CYCLES = 2,
    parameter logic [1:0]  CS_FIELD  = 2'b10,
    parameter bit          AUTO_INIT = 1'b1
) (
    input  logic             CLKX4,
    input  logic             nRESET,
    input  logic             start,
    input  logic             clr_done,
    mmu_table_init_if.slave  cpu,
    mmu_table_init_if.master mmu,
    output logic             mrdy,
    output logic             busy,
    output logic             done
);
    typedef enum logic [2:0] {IDLE, SETUP, WRITE, HOLD, DONE} state_t;

    localparam logic [7:0] LAST_IDX  = 8'(ENTRIES - 1);
    localparam logic [2:0] LAST_WCNT = 3'(WR_CYCLES - 1);

    state_t     state, state_nxt;
    logic [7:0] idx, idx_nxt;
    logic [2:0] wcnt, wcnt_nxt;
    logic       busy_nxt, done_nxt;
    logic       auto_pending, auto_nxt;
    logic [7:0] eng_addr, eng_addr_nxt;
    logic [7:0] eng_dout, eng_dout_nxt;
    logic       eng_nwr, eng_nwr_nxt;
    logic       eng_doe, eng_doe_nxt;

    function automatic logic [7:0] fill_word(input logic [7:0] i);
        return {CS_FIELD, i[5:0]};
    endfunction

    always_ff @(posedge CLKX4 or negedge nRESET) begin
        if (!nRESET) begin
            state        <= IDLE;
            idx          <= 8'd0;
            wcnt         <= 3'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            mrdy         <= 1'b1;
            auto_pending <= AUTO_INIT;
            eng_addr     <= 8'd0;
            eng_dout     <= 8'd0;
            eng_nwr      <= 1'b1;
            eng_doe      <= 1'b0;
        end else begin
            state        <= state_nxt;
            idx          <= idx_nxt;
            wcnt         <= wcnt_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            mrdy         <= !busy_nxt;
            auto_pending <= auto_nxt;
            eng_addr     <= eng_addr_nxt;
            eng_dout     <= eng_dout_nxt;
            eng_nwr      <= eng_nwr_nxt;
            eng_doe      <= eng_doe_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        wcnt_nxt     = wcnt;
        busy_nxt     = busy;
        done_nxt     = done;
        auto_nxt     = auto_pending;
        eng_addr_nxt = eng_addr;
        eng_dout_nxt = eng_dout;
        eng_nwr_nxt  = eng_nwr;
        eng_doe_nxt  = eng_doe;

        if (clr_done) done_nxt = 1'b0;

        unique case (state)
            IDLE: begin
                // start and the auto request are both consumed by one fill
                if (start || auto_pending) begin
                    state_nxt    = SETUP;
                    idx_nxt      = 8'd0;
                    busy_nxt     = 1'b1;
                    auto_nxt     = 1'b0;
                    eng_addr_nxt = 8'd0;
                    eng_dout_nxt = fill_word(8'd0);
                    eng_doe_nxt  = 1'b1;
                    eng_nwr_nxt  = 1'b1;
                end
            end
            SETUP: begin
                state_nxt   = WRITE;
                wcnt_nxt    = 3'd0;
                eng_nwr_nxt = 1'b0;
            end
            WRITE: begin
                if (wcnt == LAST_WCNT) begin
                    state_nxt   = HOLD;
                    eng_nwr_nxt = 1'b1;
                end else begin
                    wcnt_nxt = wcnt + 3'd1;
                end
            end
            HOLD: begin
                if (idx == LAST_IDX) begin
                    state_nxt   = DONE;
                    eng_doe_nxt = 1'b0;
                end else begin
                    state_nxt    = SETUP;
                    idx_nxt      = idx + 8'd1;
                    eng_addr_nxt = idx + 8'd1;
                    eng_dout_nxt = fill_word(idx + 8'd1);
                end
            end
            DONE: begin
                // set wins over a coincident clr_done
                state_nxt = IDLE;
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                idx_nxt   = 8'd0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mmu.addr = busy ? eng_addr : cpu.addr;
        mmu.nRD  = busy ? 1'b1     : cpu.nRD;
        mmu.nWR  = busy ? eng_nwr  : cpu.nWR;
        mmu.dout = busy ? eng_dout : cpu.dout;
        mmu.doe  = busy ? eng_doe  : cpu.doe;
    end
endmodule

// File: tb/tb_mmu_table_init.sv
// Bench for mmu_table_init: default instance (auto fill) and a small 8-entry instance.
module tb_mmu_table_init;
    logic CLKX4 = 1'b0;
    always #5 CLKX4 = ~CLKX4;

    logic nRESET_a, start_a, clr_done_a, mrdy_a, busy_a, done_a;
    logic nRESET_b, start_b, clr_done_b, mrdy_b, busy_b, done_b;

    mmu_table_init_if cpu_a();
    mmu_table_init_if mmu_a();
    mmu_table_init_if cpu_b();
    mmu_table_init_if mmu_b();

    mmu_table_init u_dut_a (
        .CLKX4(CLKX4), .nRESET(nRESET_a), .start(start_a), .clr_done(clr_done_a),
        .cpu(cpu_a), .mmu(mmu_a), .mrdy(mrdy_a), .busy(busy_a), .done(done_a)
    );

    mmu_table_init #(.ENTRIES(8), .WR_CYCLES(1), .CS_FIELD(2'b01), .AUTO_INIT(1'b0)) u_dut_b (
        .CLKX4(CLKX4), .nRESET(nRESET_b), .start(start_b), .clr_done(clr_done_b),
        .cpu(cpu_b), .mmu(mmu_b), .mrdy(mrdy_b), .busy(busy_b), .done(done_b)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Bus monitor / reference memory: records each completed write pulse seen on the RAM pins.
    logic       nwr_m[2], doe_m[2], busy_m[2], mrdy_m[2];
    logic [7:0] addr_m[2], dout_m[2];
    assign nwr_m[0] = mmu_a.nWR;  assign nwr_m[1] = mmu_b.nWR;
    assign doe_m[0] = mmu_a.doe;  assign doe_m[1] = mmu_b.doe;
    assign busy_m[0] = busy_a;    assign busy_m[1] = busy_b;
    assign mrdy_m[0] = mrdy_a;    assign mrdy_m[1] = mrdy_b;
    assign addr_m[0] = mmu_a.addr; assign addr_m[1] = mmu_b.addr;
    assign dout_m[0] = mmu_a.dout; assign dout_m[1] = mmu_b.dout;

    localparam int EXP_PW[2] = '{2, 1};

    logic [7:0] mem [2][256];
    int busy_cyc[2] = '{0, 0};
    int mrdy_lo[2]  = '{0, 0};
    int wr_n[2]     = '{0, 0};
    int pw_err[2]   = '{0, 0};
    int proto_err[2] = '{0, 0};
    int low_run[2]  = '{0, 0};
    logic [7:0] last_addr[2];
    logic       prev_nwr[2] = '{1'b1, 1'b1};
    logic [7:0] prev_addr[2], prev_dout[2];

    always @(negedge CLKX4) begin
        for (int k = 0; k < 2; k++) begin
            if (busy_m[k]) busy_cyc[k]++;
            if (!mrdy_m[k]) mrdy_lo[k]++;
            if (busy_m[k] && !nwr_m[k]) begin
                low_run[k]++;
                if (!doe_m[k]) proto_err[k]++;
                if (prev_nwr[k] && (addr_m[k] !== prev_addr[k] || dout_m[k] !== prev_dout[k]))
                    proto_err[k]++;
            end else if (busy_m[k] && !prev_nwr[k]) begin
                wr_n[k]++;
                mem[k][addr_m[k]] = dout_m[k];
                last_addr[k] = addr_m[k];
                if (low_run[k] != EXP_PW[k]) pw_err[k]++;
                low_run[k] = 0;
            end
            if (!busy_m[k]) low_run[k] = 0;
            prev_nwr[k]  = nwr_m[k];
            prev_addr[k] = addr_m[k];
            prev_dout[k] = dout_m[k];
        end
    end

    task automatic tick();
        @(negedge CLKX4);
        #1;
    endtask

    task automatic cpu_a_idle();
        cpu_a.addr = 8'h00; cpu_a.nRD = 1'b1; cpu_a.nWR = 1'b1; cpu_a.dout = 8'h00; cpu_a.doe = 1'b0;
    endtask

    int bc0, wr0, mr0, bad, rnd, c;
    logic [7:0] ra, rd;
    logic       rr, rw, ro;

    initial begin
        nRESET_a = 1'b0; start_a = 1'b0; clr_done_a = 1'b0;
        nRESET_b = 1'b0; start_b = 1'b0; clr_done_b = 1'b0;
        cpu_a_idle();
        cpu_b.addr = 8'h00; cpu_b.nRD = 1'b1; cpu_b.nWR = 1'b1; cpu_b.dout = 8'h00; cpu_b.doe = 1'b0;
        repeat (3) tick();

        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_mrdy", 32'(mrdy_a), 32'd1);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_nwr",  32'(mmu_a.nWR), 32'd1);
        chk("rst_doe",  32'(mmu_a.doe), 32'd0);

        // auto fill after reset release
        bc0 = busy_cyc[0]; wr0 = wr_n[0]; mr0 = mrdy_lo[0];
        nRESET_a = 1'b1;
        nRESET_b = 1'b1;
        for (c = 0; c < 2000 && !done_a; c++) tick();
        chk("auto_done",  32'(done_a), 32'd1);
        chk("auto_busy0", 32'(busy_a), 32'd0);
        chk("auto_len",   32'(busy_cyc[0] - bc0), 32'd1025);
        chk("auto_mrdy",  32'(mrdy_lo[0] - mr0), 32'd1025);
        chk("auto_wrs",   32'(wr_n[0] - wr0), 32'd256);
        chk("auto_pw",    32'(pw_err[0]), 32'd0);
        chk("auto_proto", 32'(proto_err[0]), 32'd0);
        chk("ent_2b",     32'(mem[0][8'h2B]), 32'hAB);
        chk("ent_ff",     32'(mem[0][8'hFF]), 32'hBF);
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (mem[0][i] !== 8'(8'h80 | (i % 64))) bad++;
        chk("auto_mem", 32'(bad), 32'd0);
        chk("b_no_auto", 32'(busy_cyc[1]), 32'd0);

        // passthrough while idle
        bc0 = busy_cyc[0]; wr0 = wr_n[0];
        cpu_a.addr = 8'h5A; cpu_a.nRD = 1'b0; cpu_a.doe = 1'b0;
        #1;
        chk("pt_addr", 32'(mmu_a.addr), 32'h5A);
        chk("pt_nrd",  32'(mmu_a.nRD), 32'd0);
        chk("pt_doe",  32'(mmu_a.doe), 32'd0);
        for (int i = 0; i < 8; i++) begin
            ra = 8'($urandom); rd = 8'($urandom);
            rr = 1'($urandom); rw = 1'($urandom); ro = 1'($urandom);
            cpu_a.addr = ra; cpu_a.nRD = rr; cpu_a.nWR = rw; cpu_a.dout = rd; cpu_a.doe = ro;
            #1;
            chk("pt_rand", {13'd0, mmu_a.addr, mmu_a.nRD, mmu_a.nWR, mmu_a.dout, mmu_a.doe},
                {13'd0, ra, rr, rw, rd, ro});
            tick();
        end
        cpu_a_idle();
        tick();
        chk("pt_no_busy", 32'(busy_cyc[0] - bc0), 32'd0);
        chk("pt_no_wr",   32'(wr_n[0] - wr0), 32'd0);

        // done clear, and clear while already clear
        clr_done_a = 1'b1; tick(); clr_done_a = 1'b0;
        chk("clr_done", 32'(done_a), 32'd0);
        clr_done_a = 1'b1; tick(); clr_done_a = 1'b0;
        chk("clr_idle", 32'(done_a), 32'd0);

        // start while busy ignored; clr_done in the DONE cycle loses
        bc0 = busy_cyc[0]; wr0 = wr_n[0];
        rnd = $urandom_range(2, 1000);
        start_a = 1'b1; tick(); start_a = 1'b0;
        for (int i = 1; i < 1025; i++) begin
            start_a = (i == 100) || (i == rnd);
            tick();
        end
        start_a = 1'b0;
        chk("done_cyc_busy", 32'(busy_a), 32'd1);
        chk("done_cyc_done", 32'(done_a), 32'd0);
        clr_done_a = 1'b1; tick(); clr_done_a = 1'b0;
        chk("set_wins", 32'(done_a), 32'd1);
        chk("sb_busy0", 32'(busy_a), 32'd0);
        repeat (5) tick();
        chk("sb_len", 32'(busy_cyc[0] - bc0), 32'd1025);
        chk("sb_wrs", 32'(wr_n[0] - wr0), 32'd256);

        // reset mid-fill at entry 0x40 during WRITE
        start_a = 1'b1; tick(); start_a = 1'b0;
        for (c = 0; c < 2000 && !(busy_a && mmu_a.addr == 8'h40 && mmu_a.nWR == 1'b0); c++) tick();
        chk("mid_reach", 32'(mmu_a.addr), 32'h40);
        nRESET_a = 1'b0;
        #1;
        chk("mid_nwr",  32'(mmu_a.nWR), 32'd1);
        chk("mid_doe",  32'(mmu_a.doe), 32'd0);
        chk("mid_mrdy", 32'(mrdy_a), 32'd1);
        chk("mid_busy", 32'(busy_a), 32'd0);
        chk("mid_done", 32'(done_a), 32'd0);
        tick();
        bc0 = busy_cyc[0]; wr0 = wr_n[0];
        nRESET_a = 1'b1;
        for (c = 0; c < 50 && wr_n[0] == wr0; c++) tick();
        chk("restart_idx0", 32'(last_addr[0]), 32'h00);
        for (c = 0; c < 2000 && !done_a; c++) tick();
        chk("restart_done", 32'(done_a), 32'd1);
        chk("restart_len",  32'(busy_cyc[0] - bc0), 32'd1025);
        chk("restart_wrs",  32'(wr_n[0] - wr0), 32'd256);
        chk("all_proto_a",  32'(proto_err[0]), 32'd0);

        // small instance: 8 entries, 1-cycle write, CS 01
        bc0 = busy_cyc[1]; wr0 = wr_n[1];
        start_b = 1'b1; tick(); start_b = 1'b0;
        for (c = 0; c < 200 && !done_b; c++) tick();
        chk("b_done",  32'(done_b), 32'd1);
        chk("b_len",   32'(busy_cyc[1] - bc0), 32'd25);
        chk("b_wrs",   32'(wr_n[1] - wr0), 32'd8);
        chk("b_pw",    32'(pw_err[1]), 32'd0);
        chk("b_proto", 32'(proto_err[1]), 32'd0);
        bad = 0;
        for (int i = 0; i < 8; i++)
            if (mem[1][i] !== 8'(8'h40 + i)) bad++;
        chk("b_mem", 32'(bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
